// File: rtl/univ_shift_engine.sv
// univ_shift_engine
//   Handshaked universal shift register engine. One start launches one framed
//   transfer of NB = DW/SW beats in the latched mode:
//     0 PIPO, 1 PISO MSB-first, 2 PISO LSB-first,
//     3 SIPO shift-left, 4 SIPO shift-right, 5 rotate-left; 6/7 are illegal.
//   Sequence is IDLE -> RUN -> DONE -> IDLE (mode 0 skips RUN). Every state
//   change is qualified by enb, so enb=0 freezes the whole engine.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   enb               global enable; 0 holds every register
//   start, mode       frame request and mode, sampled only in IDLE
//   par_in            parallel load word, sampled at start
//   ser_in/_vld       serial input beat and its qualifier (SIPO modes)
//   par_out           parallel result, updated only at frame end
//   ser_out/_vld      serial output beat and its qualifier (PISO/rotate)
//   busy, done, err   frame in progress / frame-end pulse / illegal-mode pulse
//   beat_cnt          beats still to move in the current frame
module univ_shift_engine #(
    parameter  int DW = 8,
    parameter  int SW = 1,
    localparam int NB = DW / SW,
    localparam int CW = $clog2(NB + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] par_in,
    input  logic [SW-1:0] ser_in,
    input  logic          ser_in_vld,
    output logic [DW-1:0] par_out,
    output logic [SW-1:0] ser_out,
    output logic          ser_out_vld,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        M_PIPO     = 3'd0,
        M_PISO_MSB = 3'd1,
        M_PISO_LSB = 3'd2,
        M_SIPO_L   = 3'd3,
        M_SIPO_R   = 3'd4,
        M_ROT_L    = 3'd5
    } mode_e;

    state_e        state_q,       state_d;
    mode_e         mode_q,        mode_d;
    logic [DW-1:0] shift_q,       shift_d;
    logic [DW-1:0] par_out_q,     par_out_d;
    logic [SW-1:0] ser_out_q,     ser_out_d;
    logic          ser_out_vld_q, ser_out_vld_d;
    logic          err_q,         err_d;
    logic [CW-1:0] beat_cnt_q,    beat_cnt_d;

    logic mode_legal;
    logic piso_mode;
    logic sipo_mode;
    logic beat_take;

    assign mode_legal = (mode <= 3'd5);
    assign piso_mode  = (mode_q == M_PISO_MSB) || (mode_q == M_PISO_LSB) ||
                        (mode_q == M_ROT_L);
    assign sipo_mode  = (mode_q == M_SIPO_L) || (mode_q == M_SIPO_R);
    // Output-side modes move a beat every enabled RUN cycle; input-side modes
    // wait for the link to present one.
    assign beat_take  = piso_mode || (sipo_mode && ser_in_vld);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statements leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        par_out_d     = par_out_q;
        ser_out_d     = ser_out_q;
        ser_out_vld_d = ser_out_vld_q;
        err_d         = err_q;
        beat_cnt_d    = beat_cnt_q;

        if (enb) begin
            err_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (mode_legal) begin
                            mode_d     = mode_e'(mode);
                            beat_cnt_d = CW'(NB);
                            // Mode 0 keeps par_in in the shift register so
                            // DONE can publish it without a separate latch.
                            if ((mode == M_SIPO_L) || (mode == M_SIPO_R)) begin
                                shift_d = '0;
                            end else begin
                                shift_d = par_in;
                            end
                            state_d = (mode == M_PIPO) ? S_DONE : S_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (beat_take) begin
                        case (mode_q)
                            M_PISO_MSB: begin
                                ser_out_d = shift_q[DW-1 -: SW];
                                shift_d   = {shift_q[DW-SW-1:0], {SW{1'b0}}};
                            end
                            M_PISO_LSB: begin
                                ser_out_d = shift_q[SW-1:0];
                                shift_d   = {{SW{1'b0}}, shift_q[DW-1:SW]};
                            end
                            M_ROT_L: begin
                                ser_out_d = shift_q[DW-1 -: SW];
                                shift_d   = {shift_q[DW-SW-1:0], shift_q[DW-1 -: SW]};
                            end
                            M_SIPO_L: shift_d = {shift_q[DW-SW-1:0], ser_in};
                            M_SIPO_R: shift_d = {ser_in, shift_q[DW-1:SW]};
                            default:  shift_d = shift_q;
                        endcase
                        if (piso_mode) begin
                            ser_out_vld_d = 1'b1;
                        end
                        beat_cnt_d = beat_cnt_q - CW'(1);
                        if (beat_cnt_q == CW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // PISO frames leave the previous parallel result intact.
                    if ((mode_q != M_PISO_MSB) && (mode_q != M_PISO_LSB)) begin
                        par_out_d = shift_q;
                    end
                    ser_out_vld_d = 1'b0;
                    beat_cnt_d    = '0;
                    state_d       = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of process ordering.
    // NOTE: the shift register is a small datapath register, not a memory, so
    // it is reset along with the control state to give a known post-reset word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mode_q        <= M_PIPO;
            shift_q       <= '0;
            par_out_q     <= '0;
            ser_out_q     <= '0;
            ser_out_vld_q <= 1'b0;
            err_q         <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            par_out_q     <= par_out_d;
            ser_out_q     <= ser_out_d;
            ser_out_vld_q <= ser_out_vld_d;
            err_q         <= err_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    assign par_out     = par_out_q;
    assign ser_out     = ser_out_q;
    assign ser_out_vld = ser_out_vld_q;
    assign err         = err_q;
    assign beat_cnt    = beat_cnt_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule
